// File: rtl/iterative_normalizer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iterative_normalizer_pkg                                                   |
// | Shared ALU types and widths for the iterative left-normalizer.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package iterative_normalizer_pkg;

  localparam int DEFAULT_NBITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } normalizer_state_e;

endpackage
`default_nettype wire

// File: rtl/iterative_normalizer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iterative_normalizer_if                                                    |
// | Operand-in / result-out valid-ready bundle for the normalizer.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface iterative_normalizer_if
  import iterative_normalizer_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
);

  localparam int CNT_W = $clog2(NBITS);

  logic [NBITS-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] out;
  logic [CNT_W-1:0] shift_amount;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  // Producer/consumer side of the normalizer
  modport master (
    output in,
    output in_valid,
    input  in_ready,
    input  out,
    input  shift_amount,
    input  zero,
    input  out_valid,
    output out_ready
  );

  // The normalizer itself
  modport slave (
    input  in,
    input  in_valid,
    output in_ready,
    output out,
    output shift_amount,
    output zero,
    output out_valid,
    input  out_ready
  );

endinterface
`default_nettype wire

// File: rtl/iterative_normalizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iterative_normalizer                                                       |
// | Shifts an operand left one bit per cycle until its MSB is set and reports  |
// | the shift count (leading-zero count); all outputs are registered.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iterative_normalizer
  import iterative_normalizer_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
)(
  input  wire                   clk,
  input  wire                   rst,
  iterative_normalizer_if.slave bus
);

  localparam int CNT_W = $clog2(NBITS);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_SHIFT = 2'(SHIFT);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [NBITS-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_in_is_zero;

  // r_in_ready is the registered image of "state is IDLE", so gating the
  // accept with it also blocks acceptance in the cycle right after reset.
  assign w_accept     = r_in_ready && bus.in_valid;
  assign w_in_is_zero = (bus.in == '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_is_zero || bus.in[NBITS-1]) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // The bit about to become the MSB ends the walk on this same edge
        if (r_work[NBITS-2]) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_work <= bus.in;
            r_cnt  <= '0;
            r_zero <= w_in_is_zero;
          end
        end
        S_SHIFT: begin
          r_work <= {r_work[NBITS-2:0], 1'b0};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out          = r_work;
  assign bus.shift_amount = r_cnt;
  assign bus.zero         = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_iterative_normalizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iterative_normalizer                                                    |
// | Directed vectors plus a leading-zero model checked every cycle.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_iterative_normalizer;
  import iterative_normalizer_pkg::*;

  localparam int NBITS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iterative_normalizer_if #(.NBITS(NBITS)) bus ();

  iterative_normalizer #(.NBITS(NBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lead_zeros(input logic [NBITS-1:0] v);
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (v[i]) return NBITS - 1 - i;
    end
    return 0;
  endfunction

  // ---------------- Model: phase 0 unknown, 1 idle, 2 busy, 3 done ----------
  int               m_phase = 0;
  int               m_left  = 0;
  logic             m_ready = 1'b0;
  logic [NBITS-1:0] m_in    = '0;
  logic [NBITS-1:0] m_out   = '0;
  int               m_sh    = 0;
  logic             m_zero  = 1'b0;
  bit               m_cmp   = 1'b0;

  always @(negedge clk) begin
    if (m_phase != 0) begin
      check("mdl out_valid", bus.out_valid, (m_phase == 3));
      check("mdl in_ready", bus.in_ready, m_ready);
      if (m_cmp) begin
        check("mdl out", bus.out, m_out);
        check("mdl shift_amount", bus.shift_amount, m_sh);
        check("mdl zero", bus.zero, m_zero);
      end
      if (bus.out_valid && !bus.zero) begin
        check("inv msb", bus.out[NBITS-1], 1'b1);
        check("inv unshift", bus.out >> bus.shift_amount, m_in);
      end
    end
    if (rst) begin
      m_phase = 1; m_out = '0; m_sh = 0; m_zero = 1'b0; m_cmp = 1'b1;
    end else begin
      case (m_phase)
        1: if (m_ready && bus.in_valid) begin
          m_in   = bus.in;
          m_zero = (bus.in == '0);
          m_sh   = m_zero ? 0 : lead_zeros(bus.in);
          m_out  = bus.in << m_sh;
          m_cmp  = 1'b0;
          if (m_sh == 0) begin
            m_phase = 3; m_cmp = 1'b1;
          end else begin
            m_phase = 2; m_left = m_sh;
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 3; m_cmp = 1'b1;
          end
        end
        3: if (bus.out_ready) begin
          m_phase = 1; m_cmp = 1'b0;
        end
        default: ;
      endcase
    end
    m_ready = !rst && (m_phase == 1);
  end

  // ---------------- Directed stimulus with literal expectations -------------
  task automatic run_op(input logic [NBITS-1:0] v, input int exp_k,
                        input logic [NBITS-1:0] exp_out, input logic exp_zero,
                        input string tag);
    int n;
    @(posedge clk); #1;
    bus.in = v; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < NBITS + 5) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, n, exp_k);
    check({tag, " out"}, bus.out, exp_out);
    check({tag, " shift_amount"}, bus.shift_amount, exp_k);
    check({tag, " zero"}, bus.zero, exp_zero);
  endtask

  task automatic expect_consumed(input string tag);
    @(posedge clk); #1;
    check({tag, " out_valid after handshake"}, bus.out_valid, 1'b0);
    check({tag, " in_ready after handshake"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    bus.in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b0);
    check("rst out", bus.out, 32'h0);
    check("rst shift_amount", bus.shift_amount, 0);
    check("rst zero", bus.zero, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready", bus.in_ready, 1'b1);

    run_op(32'h0000_0001, 31, 32'h8000_0000, 1'b0, "t1");
    expect_consumed("t1");
    run_op(32'h8000_0000, 0, 32'h8000_0000, 1'b0, "t2");
    expect_consumed("t2");
    run_op(32'h0000_0000, 0, 32'h0000_0000, 1'b1, "t3");
    expect_consumed("t3");
    run_op(32'h0001_2345, 15, 32'h91A2_8000, 1'b0, "t4");
    check("t4 unshift", bus.out >> 15, 32'h0001_2345);
    expect_consumed("t4");
    run_op(32'h4000_0000, 1, 32'h8000_0000, 1'b0, "tx1");
    expect_consumed("tx1");
    run_op(32'h0000_0003, 30, 32'hC000_0000, 1'b0, "tx2");
    expect_consumed("tx2");

    // Backpressure with a competing operand that must be ignored
    bus.out_ready = 1'b0;
    run_op(32'h00F0_0000, 8, 32'hF000_0000, 1'b0, "t5");
    repeat (5) begin
      @(posedge clk); #1;
      bus.in = 32'h0000_0001; bus.in_valid = 1'b1;
      check("t5 held out_valid", bus.out_valid, 1'b1);
      check("t5 held out", bus.out, 32'hF000_0000);
      check("t5 held shift_amount", bus.shift_amount, 8);
      check("t5 in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    expect_consumed("t5");

    // Reset ten cycles into a long operand
    @(posedge clk); #1;
    bus.in = 32'h0000_0001; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("t6 busy before reset", bus.out_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6 in_ready during reset", bus.in_ready, 1'b0);
    check("t6 out_valid during reset", bus.out_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6 out_valid after reset", bus.out_valid, 1'b0);
    check("t6 out after reset", bus.out, 32'h0);
    check("t6 in_ready after reset", bus.in_ready, 1'b1);
    run_op(32'h0000_0100, 23, 32'h8000_0000, 1'b0, "t6");
    expect_consumed("t6");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/iterative_normalizer.md
Name: iterative_normalizer

Overview:
Multi-cycle left-normalizer for the ALU datapath, and the inverse of the shift operation: it computes the shift amount instead of applying one. It takes an nBITS operand and shifts it left one bit per cycle until the MSB is 1. It returns the normalized value plus the shift count, so a logical right shift of Out by ShiftAmount recovers In. It feeds the float-pack and count-leading-zeros paths through a valid/ready handshake on both sides.

Parameters:
nBITS, 32, operand width in bits; must be >= 2.
CNT_W, $clog2(nBITS), ShiftAmount width; derived, do not override.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
In  input  nBITS  operand to normalize.
InValid  input  1  In is valid.
InReady  output  1  block can accept an operand.
Out  output  nBITS  normalized value; MSB=1 unless Zero.
ShiftAmount  output  CNT_W  number of left shifts applied, equal to the leading-zero count.
Zero  output  1  In was all-zero.
OutValid  output  1  result valid.
OutReady  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
- Reset values (after any Reset edge):
  - state = IDLE.
  - Out = 0, ShiftAmount = 0, Zero = 0, OutValid = 0.
  - InReady = 1 in the first cycle after Reset deasserts. InReady is 0 while Reset is high.
- States: IDLE, SHIFT, DONE. All outputs are registered, or decoded from state only. No combinational path from any input to any output.
- IDLE:
  - InReady = 1.
  - On an edge with InValid=1 (accept edge E0): load the working register with In and clear the count.
  - If In == 0: Out = 0, ShiftAmount = 0, Zero = 1, go to DONE.
  - Else if In[nBITS-1] == 1: go to DONE with ShiftAmount = 0.
  - Otherwise go to SHIFT.
- SHIFT:
  - InReady = 0.
  - Each edge: working register <<= 1 (zero fill), count += 1.
  - If the pre-shift bit [nBITS-2] == 1, go to DONE on that same edge.
- Latency:
  - For an operand with k leading zeros (0 <= k <= nBITS-1), OutValid rises after edge E0+k, i.e. k+1 cycles after the accept cycle.
  - Worst case is nBITS cycles.
  - Count never exceeds nBITS-1, so there is no wrap.
- DONE:
  - OutValid = 1, InReady = 0.
  - Out = working register; ShiftAmount = count.
  - Out, ShiftAmount and Zero are held stable while OutValid=1 and OutReady=0.
  - On an edge with OutReady=1: OutValid drops and state goes to IDLE.
  - No same-cycle bypass: a new operand is accepted no earlier than the cycle after the handshake.
- InValid while busy (SHIFT or DONE): ignored. The upstream holds its data under the standard valid/ready rules.
- OutReady while not in DONE: ignored.
- Reset mid-operation (SHIFT or DONE): takes priority over everything. The next cycle is IDLE with reset values, and the in-flight result is discarded with no OutValid pulse.
- Invariants:
  - When OutValid=1 and Zero=0: Out[nBITS-1] == 1, and (Out >> ShiftAmount) == the accepted In.
  - Zero=1 implies Out == 0 and ShiftAmount == 0.

Decomposition:
- The shared ALU package holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} normalizer_state_e.
  - A localparam for the default width, 32.
- Single module, no sub-module. The FSM, working register and counter are all small.

Test Plan:
1. In=0x0000_0001, OutReady=1 -> OutValid 32 cycles after accept; Out=0x8000_0000, ShiftAmount=31, Zero=0.
2. In=0x8000_0000 -> OutValid the cycle after accept; Out=0x8000_0000, ShiftAmount=0.
3. In=0x0000_0000 -> OutValid the cycle after accept; Zero=1, Out=0, ShiftAmount=0.
4. In=0x0001_2345 -> OutValid 16 cycles after accept; Out=0x91A2_8000, ShiftAmount=15; a right shift of Out by 15 equals 0x0001_2345.
5. Backpressure: In=0x00F0_0000 with OutReady=0 for 5 cycles after OutValid -> Out=0xF000_0000 and ShiftAmount=8 held stable; InReady=0; a competing InValid/In=0x1 is not accepted; result consumed when OutReady=1, IDLE the next cycle.
6. Reset asserted 10 cycles into In=0x0000_0001 -> next cycle IDLE, OutValid=0, Out=0, InReady=1, with no stray OutValid; then In=0x0000_0100 -> ShiftAmount=23, Out=0x8000_0000.
